// File: rtl/raster_output_queue.sv
// Rasterizer output queue: circular FWFT buffer between raster unit and shading stage.
// Optional occupancy/drop statistics enabled by RAS_OUTPUT_QUEUE_STATS_EN.

package raster_output_queue_pkg;
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [23:0] z;
        logic [15:0] tri_id;
    } raster_output_data_t;
endpackage

module raster_output_queue
    import raster_output_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      in_valid,
    input  raster_output_data_t       in_data,
    output logic                      fifo_full,
    output logic                      out_valid,
    output raster_output_data_t       out_data,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    count,
`ifdef RAS_OUTPUT_QUEUE_STATS_EN
    output logic [$clog2(DEPTH):0]    high_water,
    output logic [15:0]               drop_count,
`endif
    output logic                      overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    raster_output_data_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          pop;
    logic          push;
    logic          drop;
    logic          is_full;
    logic [CW-1:0] count_nxt;

    // Handshake decode; a pop frees the slot for a same-edge push when full.
    always_comb begin
        pop       = 1'b0;
        push      = 1'b0;
        drop      = 1'b0;
        is_full   = (count == CW'(DEPTH));
        pop       = out_valid && out_ready;
        push      = in_valid && (!is_full || pop);
        drop      = in_valid && is_full && !pop;
        count_nxt = count + CW'(push) - CW'(pop);
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    assign out_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            fifo_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
            fifo_full <= (count_nxt == CW'(DEPTH));
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef RAS_OUTPUT_QUEUE_STATS_EN
    // Peak occupancy since reset and saturating dropped-write counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            high_water <= '0;
            drop_count <= '0;
        end else begin
            if (count_nxt > high_water) begin
                high_water <= count_nxt;
            end
            if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_raster_output_queue.sv
// Self-checking bench for raster_output_queue: directed table, corner sequences, random vs queue model.
module tb_raster_output_queue;
    import raster_output_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                in_valid = 1'b0;
    logic                out_ready = 1'b0;
    raster_output_data_t in_data = '0;
    raster_output_data_t out_data;
    logic                fifo_full;
    logic                out_valid;
    logic                overflow;
    logic [2:0]          count;
`ifdef RAS_OUTPUT_QUEUE_STATS_EN
    logic [2:0]          high_water;
    logic [15:0]         drop_count;
`endif

    int passed = 0;
    int total  = 0;

    raster_output_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .fifo_full (fifo_full),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
`ifdef RAS_OUTPUT_QUEUE_STATS_EN
        .high_water(high_water),
        .drop_count(drop_count),
`endif
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic iv;
        int   x;
        int   y;
        logic rdy;
        int   cnt;
        logic vld;
        logic full;
        logic ovf;
        int   hx;
        int   hy;
    } vec_t;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic raster_output_data_t mk(input int x, input int y);
        raster_output_data_t r;
        r.x      = 16'(x);
        r.y      = 16'(y);
        r.z      = 24'(x * 3 + y * 7 + 1);
        r.tri_id = 16'(x ^ (y << 3));
        return r;
    endfunction

    task automatic do_reset();
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later.
    task automatic cycle(input logic iv, input raster_output_data_t d, input logic rdy);
        in_valid  = iv;
        in_data   = d;
        out_ready = rdy;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    vec_t tbl [12];
    raster_output_data_t q [$];
    raster_output_data_t rd;
    logic m_ovf;
    int   m_drops;
    int   m_hw;

    initial begin
        // Directed fill / simultaneous / overflow / drain table (DEPTH = 4).
        tbl[0]  = '{1'b1, 5, 7,   1'b0, 1, 1'b1, 1'b0, 1'b0, 5, 7};
        tbl[1]  = '{1'b0, 0, 0,   1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[2]  = '{1'b1, 0, 100, 1'b0, 1, 1'b1, 1'b0, 1'b0, 0, 100};
        tbl[3]  = '{1'b1, 1, 101, 1'b0, 2, 1'b1, 1'b0, 1'b0, 0, 100};
        tbl[4]  = '{1'b1, 2, 102, 1'b0, 3, 1'b1, 1'b0, 1'b0, 0, 100};
        tbl[5]  = '{1'b1, 3, 103, 1'b0, 4, 1'b1, 1'b1, 1'b0, 0, 100};
        tbl[6]  = '{1'b1, 8, 108, 1'b1, 4, 1'b1, 1'b1, 1'b0, 1, 101};
        tbl[7]  = '{1'b1, 9, 109, 1'b0, 4, 1'b1, 1'b1, 1'b1, 1, 101};
        tbl[8]  = '{1'b0, 0, 0,   1'b1, 3, 1'b1, 1'b0, 1'b1, 2, 102};
        tbl[9]  = '{1'b0, 0, 0,   1'b1, 2, 1'b1, 1'b0, 1'b1, 3, 103};
        tbl[10] = '{1'b0, 0, 0,   1'b1, 1, 1'b1, 1'b0, 1'b1, 8, 108};
        tbl[11] = '{1'b0, 0, 0,   1'b1, 0, 1'b0, 1'b0, 1'b1, 0, 0};

        do_reset();
        chk("rst_count", 72'(count), 72'(0));
        chk("rst_valid", 72'(out_valid), 72'(0));
        chk("rst_full", 72'(fifo_full), 72'(0));
        chk("rst_ovf", 72'(overflow), 72'(0));
`ifdef RAS_OUTPUT_QUEUE_STATS_EN
        chk("rst_hw", 72'(high_water), 72'(0));
        chk("rst_drops", 72'(drop_count), 72'(0));
`endif

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].iv, mk(tbl[i].x, tbl[i].y), tbl[i].rdy);
            chk($sformatf("tbl%0d_count", i), 72'(count), 72'(tbl[i].cnt));
            chk($sformatf("tbl%0d_valid", i), 72'(out_valid), 72'(tbl[i].vld));
            chk($sformatf("tbl%0d_full", i), 72'(fifo_full), 72'(tbl[i].full));
            chk($sformatf("tbl%0d_ovf", i), 72'(overflow), 72'(tbl[i].ovf));
            if (tbl[i].vld)
                chk($sformatf("tbl%0d_head", i), 72'(out_data), 72'(mk(tbl[i].hx, tbl[i].hy)));
        end
`ifdef RAS_OUTPUT_QUEUE_STATS_EN
        chk("tbl_drops", 72'(drop_count), 72'(1));
        chk("tbl_hw", 72'(high_water), 72'(4));
`endif

        // Stability: head held while out_ready stays low.
        do_reset();
        cycle(1'b1, mk(21, 22), 1'b0);
        cycle(1'b1, mk(23, 24), 1'b0);
        repeat (3) cycle(1'b0, mk(0, 0), 1'b0);
        chk("hold_head", 72'(out_data), 72'(mk(21, 22)));
        chk("hold_valid", 72'(out_valid), 72'(1));
        chk("hold_count", 72'(count), 72'(2));

        // Asynchronous reset between edges with three entries in flight.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(30 + i, 40 + i), 1'b0);
        chk("mid_count_pre", 72'(count), 72'(3));
        #2 resetn = 1'b0;
        #1;
        chk("mid_valid", 72'(out_valid), 72'(0));
        chk("mid_full", 72'(fifo_full), 72'(0));
        chk("mid_count", 72'(count), 72'(0));
        @(posedge clk);
        #1 resetn = 1'b1;
        cycle(1'b1, mk(42, 43), 1'b0);
        chk("post_count", 72'(count), 72'(1));
        chk("post_head", 72'(out_data), 72'(mk(42, 43)));
        cycle(1'b0, mk(0, 0), 1'b1);
        chk("post_empty", 72'(out_valid), 72'(0));
        chk("post_count0", 72'(count), 72'(0));

        // Randomized traffic against a queue model; bias alternates to hit full and empty.
        do_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
        m_hw    = 0;
        for (int c = 0; c < 600; c++) begin
            logic iv;
            logic rdy;
            logic pop;
            logic push;
            int   pin;
            pin = ((c / 100) % 2 == 1) ? 80 : 35;
            iv  = ($urandom_range(0, 99) < pin);
            rdy = ($urandom_range(0, 99) < (115 - pin));
            rd  = mk(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));

            chk("rnd_valid", 72'(out_valid), 72'(q.size() != 0));
            chk("rnd_count", 72'(count), 72'(q.size()));
            chk("rnd_full", 72'(fifo_full), 72'(q.size() == DEPTH));
            chk("rnd_ovf", 72'(overflow), 72'(m_ovf));
            if (q.size() != 0) chk("rnd_head", 72'(out_data), 72'(q[0]));

            pop  = (q.size() != 0) && rdy;
            push = iv && ((q.size() < DEPTH) || pop);
            if (iv && !push) begin
                m_ovf = 1'b1;
                m_drops++;
            end
            if (pop) void'(q.pop_front());
            if (push) q.push_back(rd);
            if (q.size() > m_hw) m_hw = q.size();
            cycle(iv, rd, rdy);
        end
        chk("rnd_end_count", 72'(count), 72'(q.size()));
`ifdef RAS_OUTPUT_QUEUE_STATS_EN
        chk("rnd_hw", 72'(high_water), 72'(m_hw));
        chk("rnd_drops", 72'(drop_count), 72'(m_drops));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/raster_output_queue.md
# raster_output_queue

Receiving end of the rasterizer output interface. Captures each `RasterOutputData` record pulsed out by the raster unit (`valid`/`output_fifo_full` handshake), stores it in a small circular buffer, and presents it to the downstream shading/shadow stage with a ready/valid handshake. Its `fifo_full` output drives the raster unit's `output_fifo_full` input and is the only back-pressure on the raster pipeline.

## Interface
- `DEPTH`, 4: number of entries. Power of two, ≥2.
- `clk` input 1: sole clock, rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `in_valid` input 1: one-cycle write pulse from the raster unit `valid`.
- `in_data` input `RasterOutputData`: record captured when `in_valid`=1.
- `fifo_full` output 1: to raster `output_fifo_full`. Registered, high when count==DEPTH.
- `out_valid` output 1: head entry available.
- `out_data` output `RasterOutputData`: head entry, first-word-fall-through.
- `out_ready` input 1: downstream accepts head when `out_valid`=1.
- `count` output $clog2(DEPTH)+1: current occupancy.
- `overflow` output 1: sticky; set when a write is dropped.
- `high_water` output $clog2(DEPTH)+1: only with `RAS_OUTPUT_QUEUE_STATS_EN`.
- `drop_count` output 16: only with `RAS_OUTPUT_QUEUE_STATS_EN`.

## Operation
- Storage: DEPTH × `RasterOutputData` array. `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. Occupancy is tracked in `count`.
- Pop condition: pop = `out_valid` && `out_ready`. `rd_ptr` increments.
- Push condition: push = `in_valid` && (count<DEPTH || pop). Writes `in_data` to mem[`wr_ptr`] and increments `wr_ptr`.
- Push while full with pop in the same cycle: accepted, because the pop frees the slot at the same edge. Count is unchanged and both pointers advance.
- Dropped write: `in_valid` while count==DEPTH and no pop. The write is dropped, pointers do not move, and `overflow` is set until reset.
- Count update: count += push − pop. It never exceeds DEPTH and never underflows.
- Head output: `out_valid` = (count!=0). `out_data` = mem[`rd_ptr`], combinational from the registered pointer. Its value is don't-care while `out_valid`=0.
- Stability: `out_data` and `out_valid` stay stable while `out_valid`=1 and `out_ready`=0.
- No reordering and no field modification. Output records are bit-identical to input records, in arrival order.
- Reset (any time, including mid-operation): pointers, count, `fifo_full`, `overflow` and stats clear immediately. Memory contents are not cleared. Entries in flight are discarded.

## Timing
- Reset values: `fifo_full`=0, `out_valid`=0, `count`=0, `overflow`=0, `high_water`=0, `drop_count`=0.
- Latency: a write at edge N gives `out_valid`=1 in the cycle after edge N. There is no same-cycle in→out bypass.
- `fifo_full` is registered and reflects count after the last edge.
- The raster unit samples `fifo_full` in its Done state and issues `valid` one edge later. At most one write is outstanding per raster cycle, so no write is lost when `fifo_full` was low at sampling.
- Pop throughput: one entry per cycle. Push throughput: one per cycle, although the raster unit produces far fewer.

## Configuration
- Macro: `RAS_OUTPUT_QUEUE_STATS_EN`.
- Defined: adds `high_water`, the maximum count since reset, updated each edge with the post-update count. Also adds `drop_count`, incremented on every dropped write and saturating at 16'hFFFF.
- Not defined: both ports and their registers are absent. All other behaviour is identical.

## Test plan
- Reset then single write: `in_valid` pulse with x=5, y=7 → `out_valid`=1 the next cycle, `out_data`.x=5, y=7, `count`=1. With `out_ready`=1 → `count`=0 and `out_valid`=0 the next cycle.
- Fill with `out_ready`=0, DEPTH=4: 4 writes with x=0..3 → `fifo_full`=1 after the 4th edge. Then drain → order x=0,1,2,3. `fifo_full` drops after the first pop.
- Overflow: full queue, `out_ready`=0, 5th `in_valid` → count stays 4 and `overflow`=1. With stats enabled, `drop_count`=1. The drained data excludes the 5th record.
- Full plus simultaneous push/pop: count=4, `in_valid` and `out_ready` both high → count stays 4, `overflow`=0, and the new record appears last.
- Wrap-around: 10 write/read pairs, interleaved with `out_ready` toggling → all 10 records come out in order, pointers wrap twice, and `high_water`≤4.
- Mid-operation reset: count=3, assert `resetn`=0 asynchronously between edges → `out_valid`, `fifo_full` and `count` are 0 immediately. After release, a new write is the only entry seen.
